// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the EX/MEM load/store port: func3 codes, the
// responder state enum, access-size decode and pipeline-register typedefs.
package dmem_responder_pkg;

   // func3 encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } dmem_state_t;

   // Access size derived from func3
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } dmem_size_t;

   // EX/MEM control bundle carried alongside the address and store data
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [2:0] func3;
   } ex_mem_ctrl_t;

   // MEM/WB register: load result and its destination valid
   typedef struct packed {
      logic        wb_valid;
      logic [31:0] wb_data;
   } mem_wb_t;

   // Unused func3 codes (3, 6, 7) fall through to a word access.
   function automatic dmem_size_t f3_size(input logic [2:0] f3);
      dmem_size_t sz;
      case (f3)
         F3_B, F3_BU: sz = SZ_BYTE;
         F3_H, F3_HU: sz = SZ_HALF;
         default:     sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for the data memory: store byte-enables and replicated
// store data, sign/zero-extended load extraction, and the alignment check.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wr_data,
   input  logic [31:0] raw_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_word,
   output logic [31:0] load_word,
   output logic        misaligned
);

   dmem_size_t  size;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Decode size, then steer lanes for both directions and flag bad alignment.
   always_comb begin
      size       = f3_size(func3);
      byte_en    = 4'b0000;
      store_word = 32'h0;
      load_word  = 32'h0;
      misaligned = 1'b0;
      byte_sel   = raw_word[{addr_lo, 3'b000} +: 8];
      half_sel   = raw_word[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: begin
            byte_en    = 4'b0001 << addr_lo;
            store_word = {4{wr_data[7:0]}};
            // func3[2] set means the unsigned variant
            load_word  = func3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_word = {2{wr_data[15:0]}};
            load_word  = func3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         default: begin
            byte_en    = 4'b1111;
            store_word = wr_data;
            load_word  = raw_word;
            misaligned = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the EX/MEM load/store port with
// programmable wait states, sub-word access and misalignment reporting.
//
// Request/stall protocol: the pipeline presents a request by raising MemRead
// and/or MemWrite with addr, wr_data and func3; the request is taken on the
// first rising edge it is seen in IDLE. mem_busy is the inverse of "ready to
// advance": while it is high the pipeline holds every input stable. The
// responder answers with a one-cycle rd_valid pulse (DONE, mem_busy low), and
// the pipeline advances at the end of that cycle. A request still present
// after DONE is treated as a new one.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic                  mem_busy,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  misaligned,
   output dmem_state_t           state_dbg
);

   localparam int         WORDS     = 1 << (DM_ADDRESS - 2);
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

   dmem_state_t           state, state_nxt;
   logic [2:0]            wait_cnt;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   ex_mem_ctrl_t          ctrl_q;
   logic                  req;
   logic                  do_write;

   logic [3:0]            byte_en;
   logic [31:0]           store_word;
   logic [31:0]           load_word;
   logic [31:0]           raw_word;
   logic                  mis;

   logic [31:0]           mem_array [WORDS];

   assign req       = MemRead | MemWrite;
   assign raw_word  = mem_array[addr_q[DM_ADDRESS-1:2]];
   assign state_dbg = state;

   dmem_lane_align u_align (
      .func3      (ctrl_q.func3),
      .addr_lo    (addr_q[1:0]),
      .wr_data    (wdata_q),
      .raw_word   (raw_word),
      .byte_en    (byte_en),
      .store_word (store_word),
      .load_word  (load_word),
      .misaligned (mis)
   );

   // Next-state and combinational stall to the pipeline.
   always_comb begin
      state_nxt = state;
      mem_busy  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               mem_busy  = 1'b1;
               state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            mem_busy = 1'b1;
            // Leave after the cycle in which the counter reads 1
            if (wait_cnt <= 3'd1) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            mem_busy  = 1'b1;
            state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset aborts any request in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Wait-state counter and request capture at acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ctrl_q   <= '0;
      end else begin
         if (state == ST_IDLE && req) begin
            wait_cnt         <= WAIT_LOAD;
            addr_q           <= addr;
            wdata_q          <= wr_data;
            ctrl_q.func3     <= func3;
            // Both strobes high resolves to a store
            ctrl_q.mem_write <= MemWrite;
            ctrl_q.mem_read  <= MemRead & ~MemWrite;
         end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
      end
   end

   // A misaligned store never touches the array.
   assign do_write = (state == ST_ACCESS) && ctrl_q.mem_write && !mis && !reset;

   // Byte-enabled array write on the edge that leaves ACCESS.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem_array[addr_q[DM_ADDRESS-1:2]][8*i +: 8] <= store_word[8*i +: 8];
         end
      end
   end

   // Completion pulse, error flag and registered load data for DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid   <= 1'b0;
         misaligned <= 1'b0;
         rd_data    <= '0;
      end else begin
         rd_valid   <= (state == ST_ACCESS);
         misaligned <= (state == ST_ACCESS) && mis;
         if (state == ST_ACCESS && ctrl_q.mem_read) begin
            rd_data <= mis ? '0 : load_word;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (one and zero wait states) driven
// by directed requests, a byte-level memory model and a per-cycle compare.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=0
  logic        mr [2];
  logic        mw [2];
  logic [8:0]  ad [2];
  logic [31:0] wd [2];
  logic [2:0]  f3 [2];
  logic        busy [2];
  logic        vld [2];
  logic        mis [2];
  logic [31:0] rdd [2];
  dmem_state_t dbg [2];

  int wc [2] = '{1, 0};

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
    .wr_data(wd[0]), .func3(f3[0]), .mem_busy(busy[0]), .rd_valid(vld[0]),
    .rd_data(rdd[0]), .misaligned(mis[0]), .state_dbg(dbg[0])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
    .wr_data(wd[1]), .func3(f3[1]), .mem_busy(busy[1]), .rd_valid(vld[1]),
    .rd_data(rdd[1]), .misaligned(mis[1]), .state_dbg(dbg[1])
  );

  // ---------------- model state ----------------
  logic [7:0]  mb [2][512];
  logic        act [2];
  int          st [2];
  logic        e_load [2];
  logic        e_mis [2];
  logic [31:0] e_val [2];
  logic [31:0] exp_rd [2];
  logic [31:0] exp_q [$];
  logic        run = 1'b0;
  int          last_lat;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
    end else if (run) begin
      for (int d = 0; d < 2; d++) begin
        int k;
        logic eb, ev;
        k  = cyc - st[d];
        eb = act[d] && (k <= wc[d] + 1);
        ev = act[d] && (k == wc[d] + 2);
        if (ev && e_load[d]) exp_rd[d] = e_mis[d] ? 32'h0 : e_val[d];
        check($sformatf("busy%0d", d), {31'b0, busy[d]}, {31'b0, eb});
        check($sformatf("valid%0d", d), {31'b0, vld[d]}, {31'b0, ev});
        check($sformatf("mis%0d", d), {31'b0, mis[d]}, {31'b0, ev & e_mis[d]});
        check($sformatf("rd_data%0d", d), rdd[d], exp_rd[d]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input int d, input logic r, input logic w, input logic [2:0] f,
                        input logic [8:0] a, input logic [31:0] data,
                        input logic chk, input logic [31:0] lit, input logic lit_mis);
    int size, nb;
    logic [31:0] v;
    @(posedge clk); #1;
    mr[d] = r; mw[d] = w; f3[d] = f; ad[d] = a; wd[d] = data;
    size = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    e_mis[d]  = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
    e_load[d] = r && !w;
    if (w && !e_mis[d])
      for (int i = 0; i < size; i++) mb[d][int'(a) + i] = data[8*i +: 8];
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(mb[d][int'(a) + i]) << (8 * i));
    if (f == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f == 3'd1) v = {{16{v[15]}}, v[15:0]};
    e_val[d] = v;
    if (chk) exp_q.push_back(lit);
    st[d] = cyc; act[d] = 1'b1;
    nb = 0;
    last_lat = -1;
    for (int k = 0; k < wc[d] + 3; k++) begin
      @(negedge clk);
      nb += int'(busy[d]);
      if (vld[d] && last_lat < 0) last_lat = k;
    end
    check($sformatf("busy_cycles%0d", d), 32'(nb), 32'(wc[d] + 2));
    check($sformatf("lit_mis%0d", d), {31'b0, mis[d]}, {31'b0, lit_mis});
    if (chk) check($sformatf("lit_rd%0d@%h", d, a), rdd[d], exp_q.pop_front());
    @(posedge clk); #1;
    mr[d] = 1'b0; mw[d] = 1'b0;
    act[d] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 0; mw[d] = 0; f3[d] = 0; ad[d] = 0; wd[d] = 0;
      act[d] = 0; st[d] = 0; e_load[d] = 0; e_mis[d] = 0; e_val[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy[0]}, 32'h0);
    check("rst_valid", {31'b0, vld[0]}, 32'h0);
    check("rst_mis", {31'b0, mis[0]}, 32'h0);
    check("rst_rd", rdd[0], 32'h0);
    check("rst_state", 32'(dbg[0]), 32'(ST_IDLE));
    rst = 1'b0;
    run = 1'b1;

    // word write/read, latency and sub-word loads
    do_req(0, 0, 1, 3'd2, 9'h010, 32'hDEADBEEF, 0, 0, 0);
    do_req(0, 1, 0, 3'd2, 9'h010, 0, 1, 32'hDEADBEEF, 0);
    check("lat_w1", 32'(last_lat), 32'd3);
    do_req(0, 1, 0, 3'd0, 9'h013, 0, 1, 32'hFFFFFFDE, 0);
    do_req(0, 1, 0, 3'd4, 9'h013, 0, 1, 32'h000000DE, 0);
    do_req(0, 1, 0, 3'd1, 9'h012, 0, 1, 32'hFFFFDEAD, 0);
    do_req(0, 1, 0, 3'd5, 9'h010, 0, 1, 32'h0000BEEF, 0);

    // sub-word stores
    do_req(0, 0, 1, 3'd0, 9'h011, 32'h00000055, 0, 0, 0);
    do_req(0, 1, 0, 3'd2, 9'h010, 0, 1, 32'hDEAD55EF, 0);
    do_req(0, 0, 1, 3'd1, 9'h012, 32'h00001234, 0, 0, 0);
    do_req(0, 1, 0, 3'd2, 9'h010, 0, 1, 32'h123455EF, 0);
    do_req(0, 1, 0, 3'd3, 9'h010, 0, 1, 32'h123455EF, 0);

    // misaligned accesses
    do_req(0, 1, 0, 3'd2, 9'h011, 0, 1, 32'h00000000, 1);
    do_req(0, 0, 1, 3'd1, 9'h013, 32'h0000BEEF, 0, 0, 1);
    do_req(0, 1, 0, 3'd2, 9'h010, 0, 1, 32'h123455EF, 0);

    // reset during WAIT aborts the store
    do_req(0, 0, 1, 3'd2, 9'h020, 32'h01020304, 0, 0, 0);
    @(posedge clk); #1;
    mw[0] = 1'b1; f3[0] = 3'd2; ad[0] = 9'h020; wd[0] = 32'hAAAAAAAA;
    act[0] = 1'b0;
    run = 1'b0;
    @(posedge clk); #1;
    check("in_wait", 32'(dbg[0]), 32'(ST_WAIT));
    rst = 1'b1;
    mw[0] = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy[0]}, 32'h0);
    check("abort_valid", {31'b0, vld[0]}, 32'h0);
    check("abort_mis", {31'b0, mis[0]}, 32'h0);
    check("abort_rd", rdd[0], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;
    do_req(0, 1, 0, 3'd2, 9'h020, 0, 1, 32'h01020304, 0);

    // zero wait states; both strobes high is a store
    do_req(1, 1, 1, 3'd2, 9'h030, 32'hCAFEF00D, 0, 0, 0);
    do_req(1, 1, 0, 3'd2, 9'h030, 0, 1, 32'hCAFEF00D, 0);
    check("lat_w0", 32'(last_lat), 32'd2);
    do_req(1, 1, 0, 3'd1, 9'h032, 0, 1, 32'hFFFFCAFE, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // bound the run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target end of the EX/MEM-stage load/store port. It accepts one request at a time, inserts a programmable number of wait states, performs byte/half/word accesses with RISC-V sub-word semantics, and returns sign- or zero-extended load data. It also drives a stall back to the pipeline and flags misaligned accesses.

## Interface
- DM_ADDRESS, 9: byte-address width; the array holds 2^(DM_ADDRESS-2) 32-bit words.
- DATA_W, 32: data width. Fixed at 32.
- WAIT_CYCLES, 1: wait states inserted before the array access. Legal range 0..7.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- addr  in  DM_ADDRESS  byte address.
- wr_data  in  DATA_W  store data, taken from the low-order bytes.
- func3  in  3  access size and sign: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. For stores: 0 sb, 1 sh, 2 sw.
- mem_busy  out  1  stall to the pipeline. Combinational.
- rd_valid  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  extended load data. Registered.
- misaligned  out  1  one-cycle error pulse, coincident with rd_valid.

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS, DONE.
  - IDLE → WAIT when MemRead or MemWrite is high. Address, data, func3 and kind are latched at that edge. If WAIT_CYCLES=0, the transition goes to ACCESS instead.
  - WAIT: a counter loaded with WAIT_CYCLES decrements each cycle. The FSM moves to ACCESS after the cycle in which the counter reads 1.
  - ACCESS: the array is read or written on the edge that leaves ACCESS. Next state is DONE.
  - DONE: rd_valid=1. Next state is IDLE unconditionally; no request is accepted while in DONE.
- mem_busy = (IDLE and (MemRead or MemWrite)) or WAIT or ACCESS. It is 0 in DONE.
- The requester holds all inputs stable while mem_busy=1 and advances at the end of DONE.
- If MemRead and MemWrite are both high, the request is a store.
- func3 values 3, 6 and 7 are treated as word accesses.
- Stores:
  - sb writes byte lane addr[1:0] with wr_data[7:0].
  - sh writes lanes {addr[1],0}..+1 with wr_data[15:0].
  - sw writes all four lanes.
  - Unselected lanes are unchanged.
- Loads select the byte or half at the latched address.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - rd_data updates only on a load that completes, and holds its value otherwise.
- Misalignment:
  - Defined as half with addr[0]=1, or word with addr[1:0]≠0.
  - No array access takes place, and latency is unchanged.
  - In DONE, misaligned=1. On a load, rd_data becomes 0.
- addr bits above DM_ADDRESS-1 do not exist; word index = addr[DM_ADDRESS-1:2].

## Timing
- A request seen in IDLE at cycle 0 gives: ACCESS at cycle 1+WAIT_CYCLES, DONE (rd_valid, valid rd_data) at cycle 2+WAIT_CYCLES.
- mem_busy is high for cycles 0..1+WAIT_CYCLES.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE, so throughput is one access per 3+WAIT_CYCLES cycles.
- Reset values: state IDLE, counter 0, rd_data 0, rd_valid 0, misaligned 0. mem_busy is 0 unless a request is present in IDLE.
- The array is not reset.
- Reset asserted during WAIT or ACCESS aborts the request. If reset arrives before the ACCESS exit edge, the write does not happen.
- After reset deasserts, a still-present request is accepted as new.
- Load data is a registered output; no combinational path from addr to rd_data.

## Structure
- Shared package: the func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum dmem_state_t, alongside the existing pipeline-register typedefs.
- One combinational sub-module, dmem_lane_align. It produces:
  - the 4-bit byte-enable and shifted store word from func3, addr[1:0] and wr_data;
  - the extended load word from the raw word, func3 and addr[1:0];
  - the misaligned flag.
- Array: a behavioural reg array with byte-enable write, one read per access.

## Test plan
- With WAIT_CYCLES=1: sw 0xDEADBEEF @0x10, then lw @0x10. Required: rd_valid at cycle 3 after acceptance, rd_data=0xDEADBEEF, mem_busy high for exactly cycles 0–2.
- Loads of that word:
  - lb @0x13 → 0xFFFFFFDE
  - lbu @0x13 → 0x000000DE
  - lh @0x12 → 0xFFFFDEAD
  - lhu @0x10 → 0x0000BEEF
- sb 0x55 @0x11 over 0xDEADBEEF, then lw @0x10 → 0xDEAD55EF. sh 0x1234 @0x12, then lw → 0x123455EF.
- Misaligned accesses:
  - lw @0x11 → misaligned=1 and rd_data=0 in DONE.
  - sh @0x13 → misaligned=1 and the memory word is unchanged.
- Reset asserted during WAIT of sw 0xAAAAAAAA @0x20 (old value 0x01020304). Required: all outputs 0, and after release a lw @0x20 returns 0x01020304.
- With WAIT_CYCLES=0: lw gives rd_valid 2 cycles after acceptance. With both MemRead and MemWrite high, the store is performed.
